// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the core and the iterative multiply/divide unit.
interface muldiv_seq_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, funct3, a, b, input busy, done, result);
  modport slave  (input start, funct3, a, b, output busy, done, result);
endinterface

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide: shift-add multiply, restoring divide,
// sign fix-up in a final cycle. Divide-by-zero and signed overflow bypass
// the iterations and complete in one cycle.
module muldiv_seq #(
  parameter int unsigned XLEN = 32
) (
  input  logic         clk,
  input  logic         reset,
  muldiv_seq_if.slave  bus
);

  localparam int unsigned CW = $clog2(XLEN + 1);
  localparam int unsigned AW = 2 * XLEN;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   count;
  logic [AW-1:0]   acc;      // mul: {partial hi, multiplier}; div: {remainder, quotient}
  logic [XLEN-1:0] opnd;     // mul: multiplicand magnitude; div: divisor magnitude
  logic [2:0]      op;
  logic            neg;      // negate the selected result in FIX
  logic [XLEN-1:0] result_q;

  // Request decode: signedness, magnitudes and special divide cases
  logic            is_div;
  logic            sgn_a;
  logic            sgn_b;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic            div_zero;
  logic            div_ovf;
  logic            special;
  logic [XLEN-1:0] special_res;
  logic            neg_nxt;

  // Decode the operation presented in IDLE
  always_comb begin
    is_div      = bus.funct3[2];
    sgn_a       = is_div ? ~bus.funct3[0] : (bus.funct3[1:0] != 2'b11);
    sgn_b       = is_div ? ~bus.funct3[0] : ~bus.funct3[1];
    a_neg       = sgn_a & bus.a[XLEN-1];
    b_neg       = sgn_b & bus.b[XLEN-1];
    mag_a       = a_neg ? (XLEN'(0) - bus.a) : bus.a;
    mag_b       = b_neg ? (XLEN'(0) - bus.b) : bus.b;
    div_zero    = (bus.b == '0);
    div_ovf     = ~bus.funct3[0] & (bus.a == {1'b1, {(XLEN-1){1'b0}}}) & (bus.b == '1);
    special     = is_div & (div_zero | div_ovf);
    special_res = '0;
    if (div_zero) begin
      special_res = bus.funct3[1] ? bus.a : '1;
    end else begin
      special_res = bus.funct3[1] ? '0 : bus.a;
    end
    // remainder follows the dividend; product and quotient follow the sign difference
    neg_nxt = (is_div & bus.funct3[1]) ? a_neg : (a_neg ^ b_neg);
  end

  // One iteration of each datapath and the final sign/select step
  logic [XLEN:0]   mul_sum;
  logic [AW-1:0]   mul_next;
  logic [XLEN:0]   div_sh;
  logic [XLEN:0]   div_trial;
  logic            div_ok;
  logic [AW-1:0]   div_next;
  logic [AW-1:0]   prod;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] fix_res;

  // Shift-add step, restoring-divide step and FIX result selection
  always_comb begin
    mul_sum   = {1'b0, acc[AW-1:XLEN]} + (acc[0] ? {1'b0, opnd} : (XLEN+1)'(0));
    mul_next  = {mul_sum, acc[XLEN-1:1]};
    div_sh    = {acc[AW-1:XLEN], acc[XLEN-1]};
    div_trial = div_sh - {1'b0, opnd};
    div_ok    = ~div_trial[XLEN];
    div_next  = {(div_ok ? div_trial[XLEN-1:0] : div_sh[XLEN-1:0]), acc[XLEN-2:0], div_ok};
    prod      = neg ? (AW'(0) - acc) : acc;
    quo       = acc[XLEN-1:0];
    rem       = acc[AW-1:XLEN];
    fix_res   = '0;
    case (op)
      3'b000:                 fix_res = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod[AW-1:XLEN];
      3'b100, 3'b101:         fix_res = neg ? (XLEN'(0) - quo) : quo;
      default:                fix_res = neg ? (XLEN'(0) - rem) : rem;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          if (special) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = is_div ? S_DIV : S_MUL;
          end
        end
      end
      S_MUL:   if (count == CW'(1)) state_nxt = S_FIX;
      S_DIV:   if (count == CW'(1)) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Status outputs decoded from state only
  always_comb begin
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    bus.result = result_q;
    if (state != S_IDLE) bus.busy = 1'b1;
    if (state == S_DONE) bus.done = 1'b1;
  end

  // Operand capture, iteration and result register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count    <= '0;
      acc      <= '0;
      opnd     <= '0;
      op       <= '0;
      neg      <= 1'b0;
      result_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            op    <= bus.funct3;
            neg   <= neg_nxt;
            count <= CW'(XLEN);
            if (is_div) begin
              acc  <= {{XLEN{1'b0}}, mag_a};
              opnd <= mag_b;
            end else begin
              acc  <= {{XLEN{1'b0}}, mag_b};
              opnd <= mag_a;
            end
            if (special) result_q <= special_res;
          end
        end
        S_MUL: begin
          acc   <= mul_next;
          count <= count - CW'(1);
        end
        S_DIV: begin
          acc   <= div_next;
          count <= count - CW'(1);
        end
        S_FIX:   result_q <= fix_res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: expected results are queued when a request
// is driven and compared, with latency, when done pulses.
module tb_muldiv_seq;
  localparam int unsigned XLEN = 32;
  localparam int LAT = XLEN + 2;

  logic clk = 1'b0;
  logic reset = 1'b1;

  muldiv_seq_if #(.XLEN(XLEN)) bus ();
  muldiv_seq #(.XLEN(XLEN)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          c0;
  } exp_t;

  exp_t  sb[$];
  string tags[$];
  int    errors = 0;
  int    checks = 0;
  logic [31:0] last_res = '0;
  logic  prev_done = 1'b0;
  exp_t  e;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference results from 64-bit host arithmetic
  function automatic logic [31:0] model(input logic [2:0] fn, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, ux, uy, q;
    logic [63:0] p;
    logic ovf;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    ux  = longint'({32'b0, x});
    uy  = longint'({32'b0, y});
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    p   = '0;
    q   = 0;
    case (fn)
      3'd0: begin p = 64'(ux * uy); return p[31:0]; end
      3'd1: begin p = 64'(sx * sy); return p[63:32]; end
      3'd2: begin p = 64'(sx * uy); return p[63:32]; end
      3'd3: begin p = 64'(ux * uy); return p[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (ovf) return x;
        q = sx / sy; p = 64'(q); return p[31:0];
      end
      3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 0) return x;
        if (ovf) return 32'h0;
        q = sx % sy; p = 64'(q); return p[31:0];
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] fn, input logic [31:0] x, input logic [31:0] y);
    if (fn[2] && (y == 0 || (!fn[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF))) return 1;
    return LAT;
  endfunction

  // Output monitor: pop on done, check result, latency, pulse width, hold
  always @(negedge clk) begin
    if (reset) begin
      last_res  = '0;
      prev_done = 1'b0;
    end else begin
      if (bus.done) begin
        check("done_width", prev_done, 0);
        check("done_expected", 64'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check(tags.pop_front(), bus.result, e.res);
          check("latency", 64'(cyc - e.c0), 64'(e.lat));
        end
        last_res = bus.result;
      end else begin
        check("hold", bus.result, last_res);
      end
      prev_done = bus.done;
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      check("timeout", 64'(sb.size()), 0);
      sb.delete();
      tags.delete();
    end
    @(negedge clk);
    check("busy_after_done", bus.busy, 0);
  endtask

  task automatic run_op(input string tag, input logic [2:0] fn, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp, input int lat);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = fn;
    bus.a      = x;
    bus.b      = y;
    sb.push_back('{exp, lat, cyc});
    tags.push_back(tag);
    @(negedge clk);
    bus.start  = 1'b0;
    bus.funct3 = 3'($urandom);
    bus.a      = $urandom;
    bus.b      = $urandom;
    check({tag, "_busy1"}, bus.busy, 1);
    #1;
    wait_idle();
  endtask

  initial begin
    logic [2:0]  fn;
    logic [31:0] x, y;
    int c0;

    bus.start  = 1'b0;
    bus.funct3 = '0;
    bus.a      = '0;
    bus.b      = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_result", bus.result, 0);
    reset = 1'b0;

    // Directed operations
    run_op("mul",    3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT);
    run_op("mulh",   3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, LAT);
    run_op("mulhu",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT);
    run_op("div",    3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, LAT);
    run_op("rem",    3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, LAT);
    run_op("divu",   3'd5, 32'hFFFF_FFF9,  32'd2,         32'h7FFF_FFFC, LAT);
    run_op("remu",   3'd7, 32'hFFFF_FFF9,  32'd2,         32'h0000_0001, LAT);
    run_op("div0",   3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1);
    run_op("remu0",  3'd7, 32'd5,          32'd0,         32'd5,         1);
    run_op("divovf", 3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("removf", 3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         1);

    // Random operations, including special divide operands
    for (int i = 0; i < 24; i++) begin
      fn = 3'($urandom);
      x  = $urandom;
      y  = $urandom;
      if (i % 4 == 1) y = '0;
      if (i % 8 == 3) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
      if (i % 8 == 5) x = 32'hFFFF_FFFF;
      run_op("rand", fn, x, y, model(fn, x, y), model_lat(fn, x, y));
    end

    // start held high with operands changing every cycle
    @(negedge clk);
    c0 = cyc;
    bus.start = 1'b1;
    for (int k = 0; k <= 72; k++) begin
      if (k > 0) @(negedge clk);
      fn = 3'($urandom);
      x  = $urandom;
      y  = ($urandom & 32'h7FFF_FFFF) | 32'h1;
      bus.funct3 = fn;
      bus.a      = x;
      bus.b      = y;
      if (k == 0 || k == LAT + 1 || k == 2 * (LAT + 1)) begin
        sb.push_back('{model(fn, x, y), LAT, cyc});
        tags.push_back("b2b");
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    wait_idle();

    // Reset in the middle of a divide
    run_op("pre_rst", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = 3'd4;
    bus.a      = 32'd100;
    bus.b      = 32'd7;
    sb.push_back('{32'd14, LAT, cyc});
    tags.push_back("aborted_div");
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_busy", bus.busy, 0);
    check("arst_done", bus.done, 0);
    check("arst_result", bus.result, 0);
    sb.delete();
    tags.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("post_rst_idle", bus.busy, 0);
    run_op("mul_after_rst", 3'd0, 32'd3, 32'd4, 32'd12, LAT);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
